// File: rtl/data_c_pipe_intc_m2s_addr_queue.sv
// NUM-to-1 packet interconnect: queued routing addresses select one slave channel per packet,
// with a two-entry skid output stage. Optional packet counter under `M2S_PKT_STAT_EN.
module data_c_pipe_intc_m2s_addr_queue #(
    parameter int NUM        = 8,
    parameter int DSIZE      = 32,
    parameter int ADDR_DEPTH = 4,
    localparam int ASIZE     = (NUM > 1) ? $clog2(NUM) : 1
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 addr_valid,
    input  logic [ASIZE-1:0]     addr_data,
    output logic                 addr_ready,
    input  logic [NUM-1:0]       s_valid,
    input  logic [NUM*DSIZE-1:0] s_data,
    input  logic [NUM-1:0]       s_last,
    output logic [NUM-1:0]       s_ready,
    output logic                 m_valid,
    output logic [DSIZE-1:0]     m_data,
    output logic                 m_last,
    input  logic                 m_ready,
    output logic                 err_addr,
    output logic [31:0]          pkt_cnt
);

    localparam int AW = $clog2(ADDR_DEPTH);
    localparam logic [ASIZE:0] NUM_W   = (ASIZE + 1)'(NUM);
    localparam logic [AW:0]    DEPTH_W = (AW + 1)'(ADDR_DEPTH);

    logic [ASIZE-1:0] q_mem [ADDR_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      q_cnt;
    logic             q_empty;
    logic             q_full;
    logic             push;
    logic             pop;
    logic [ASIZE-1:0] head;
    logic             head_ok;

    logic [ASIZE-1:0] path;
    logic             path_vld;
    logic             sel_valid;
    logic             sel_last;
    logic [DSIZE-1:0] sel_data;
    logic             acc;
    logic             last_acc;
    logic             err_q;

    logic             out_vld;
    logic             out_last;
    logic [DSIZE-1:0] out_data;
    logic             sk_vld;
    logic             sk_last;
    logic [DSIZE-1:0] sk_data;

    assign q_empty    = (q_cnt == '0);
    assign q_full     = (q_cnt == DEPTH_W);
    assign addr_ready = !q_full;
    assign push       = addr_valid && !q_full;
    assign head       = q_mem[rd_ptr];
    assign head_ok    = ({1'b0, head} < NUM_W);

    // Address queue; reading happens only from registered storage, so no write-through.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q_cnt  <= '0;
            for (int i = 0; i < ADDR_DEPTH; i++) begin
                q_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                q_mem[wr_ptr] <= addr_data;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   q_cnt <= q_cnt + 1'b1;
                2'b01:   q_cnt <= q_cnt - 1'b1;
                default: q_cnt <= q_cnt;
            endcase
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int k = 0; k < NUM; k++) begin
            if (path == ASIZE'(k)) begin
                sel_valid = s_valid[k];
                sel_last  = s_last[k];
                sel_data  = s_data[k*DSIZE +: DSIZE];
            end
        end
    end

    // Ready depends only on registers so upstream never sees a valid->ready loop.
    always_comb begin
        s_ready = '0;
        for (int k = 0; k < NUM; k++) begin
            s_ready[k] = path_vld && (path == ASIZE'(k)) && !sk_vld;
        end
    end

    assign acc      = path_vld && !sk_vld && sel_valid;
    assign last_acc = acc && sel_last;
    assign pop      = !q_empty && (!path_vld || last_acc);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            path     <= '0;
            path_vld <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (pop) begin
                if (head_ok) begin
                    path     <= head;
                    path_vld <= 1'b1;
                end else begin
                    path_vld <= 1'b0;
                    err_q    <= 1'b1;
                end
            end else if (last_acc) begin
                path_vld <= 1'b0;
            end
        end
    end

    assign err_addr = err_q;

    // A beat only lands in skid when out is occupied and stalled; skid drains first.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_last <= 1'b0;
            out_data <= '0;
            sk_vld   <= 1'b0;
            sk_last  <= 1'b0;
            sk_data  <= '0;
        end else begin
            if (sk_vld) begin
                if (m_ready) begin
                    out_vld  <= 1'b1;
                    out_data <= sk_data;
                    out_last <= sk_last;
                    sk_vld   <= 1'b0;
                end
            end else if (acc) begin
                if (!out_vld || m_ready) begin
                    out_vld  <= 1'b1;
                    out_data <= sel_data;
                    out_last <= sel_last;
                end else begin
                    sk_vld  <= 1'b1;
                    sk_data <= sel_data;
                    sk_last <= sel_last;
                end
            end else if (m_ready) begin
                out_vld <= 1'b0;
            end
        end
    end

    assign m_valid = out_vld;
    assign m_data  = out_data;
    assign m_last  = out_last;

`ifdef M2S_PKT_STAT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (out_vld && m_ready && out_last) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign pkt_cnt = cnt_q;
`else
    assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_data_c_pipe_intc_m2s_addr_queue.sv
// Randomized bench for the NUM-to-1 packet interconnect; expected beats come from a
// packet-order model built when each address/packet is scheduled.
`timescale 1ns/1ps
module tb_data_c_pipe_intc_m2s_addr_queue;

    localparam int NUM   = 6;
    localparam int DSIZE = 32;
    localparam int DEPTH = 4;
    localparam int ASIZE = 3;

    logic                 clock = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 addr_valid = 1'b0;
    logic [ASIZE-1:0]     addr_data = '0;
    logic                 addr_ready;
    logic [NUM-1:0]       s_valid = '0;
    logic [NUM*DSIZE-1:0] s_data = '0;
    logic [NUM-1:0]       s_last = '0;
    logic [NUM-1:0]       s_ready;
    logic                 m_valid;
    logic [DSIZE-1:0]     m_data;
    logic                 m_last;
    logic                 m_ready = 1'b0;
    logic                 err_addr;
    logic [31:0]          pkt_cnt;

    data_c_pipe_intc_m2s_addr_queue #(.NUM(NUM), .DSIZE(DSIZE), .ADDR_DEPTH(DEPTH)) dut (
        .clock(clock), .rst_n(rst_n),
        .addr_valid(addr_valid), .addr_data(addr_data), .addr_ready(addr_ready),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .err_addr(err_addr), .pkt_cnt(pkt_cnt)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    logic [31:0] src_data [NUM][256];
    logic        src_last [NUM][256];
    int          src_head [NUM];
    int          src_tail [NUM];
    logic [32:0] exp_q [$];
    int          acc_order [$];
    int          pend [$];
    int          exp_err, obs_err, exp_pkts, inflight;
    logic        stalled;
    logic [31:0] held_data;
    logic        held_last;
    int          vld_prob, rdy_prob, addr_prob;
    int          smp_acc, smp_out;
    logic        smp_mvalid, smp_addr_ready;
    logic [NUM-1:0] smp_s_ready;

    function automatic logic [31:0] exp_cnt();
`ifdef M2S_PKT_STAT_EN
        return 32'(exp_pkts);
`else
        return 32'd0;
`endif
    endfunction

    task automatic clear_model();
        for (int k = 0; k < NUM; k++) begin
            src_head[k] = 0;
            src_tail[k] = 0;
        end
        exp_q.delete();
        acc_order.delete();
        pend.delete();
        exp_err = 0; obs_err = 0; exp_pkts = 0; inflight = 0;
        stalled = 1'b0; held_data = '0; held_last = 1'b0;
        vld_prob = 100; rdy_prob = 100; addr_prob = 100;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        addr_valid = 1'b0; addr_data = '0;
        s_valid = '0; s_data = '0; s_last = '0; m_ready = 1'b0;
        clear_model();
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
    endtask

    // base < 0 selects random beat data
    task automatic add_pkt(input int ch, input int len, input int base);
        logic [31:0] d;
        pend.push_back(ch);
        if (ch >= NUM) begin
            exp_err++;
        end else begin
            for (int i = 0; i < len; i++) begin
                d = (base < 0) ? $urandom : 32'(base + i);
                src_data[ch][src_tail[ch]] = d;
                src_last[ch][src_tail[ch]] = (i == len - 1);
                src_tail[ch]++;
                exp_q.push_back({(i == len - 1), d});
                acc_order.push_back(ch);
            end
        end
    endtask

    task automatic cycle();
        logic [32:0]    e;
        logic [NUM-1:0] exp_rdy;
        int             nin, nout;
        nin = 0; nout = 0;
        @(negedge clock);
        addr_valid = (pend.size() > 0) && (int'($urandom_range(99)) < addr_prob);
        addr_data  = (pend.size() > 0) ? ASIZE'(pend[0]) : ASIZE'($urandom_range(7));
        for (int k = 0; k < NUM; k++) begin
            if (src_head[k] < src_tail[k]) begin
                s_valid[k] = int'($urandom_range(99)) < vld_prob;
                s_data[k*DSIZE +: DSIZE] = src_data[k][src_head[k]];
                s_last[k] = src_last[k][src_head[k]];
            end else begin
                s_valid[k] = 1'b0;
                s_data[k*DSIZE +: DSIZE] = $urandom;
                s_last[k] = 1'($urandom_range(1));
            end
        end
        m_ready = int'($urandom_range(99)) < rdy_prob;
        #4;
        total++;
        if ($countones(s_ready) > 1) begin
            bad++; $display("FAIL s_ready_onehot got=%b want=at_most_one_bit", s_ready);
        end
        if (s_ready != '0) begin
            exp_rdy = '0;
            if (acc_order.size() > 0) exp_rdy[acc_order[0]] = 1'b1;
            total++;
            if (s_ready !== exp_rdy) begin
                bad++; $display("FAIL s_ready_channel got=%b want=%b", s_ready, exp_rdy);
            end
        end
        if (stalled) begin
            total++;
            if (m_valid !== 1'b1 || m_data !== held_data || m_last !== held_last) begin
                bad++; $display("FAIL stall_hold got=%b/%h/%b want=1/%h/%b",
                                m_valid, m_data, m_last, held_data, held_last);
            end
        end
        if (m_valid && m_ready) begin
            nout = 1;
            inflight--;
            total++;
            if (exp_q.size() == 0) begin
                bad++; $display("FAIL out_beat got=%b/%h want=no_beat", m_last, m_data);
            end else begin
                e = exp_q.pop_front();
                if (e[32]) exp_pkts++;
                if ({m_last, m_data} !== e) begin
                    bad++; $display("FAIL out_beat got=%b/%h want=%b/%h", m_last, m_data, e[32], e[31:0]);
                end
            end
        end
        for (int k = 0; k < NUM; k++) begin
            if (s_valid[k] && s_ready[k]) begin
                src_head[k]++;
                inflight++;
                nin++;
                if (acc_order.size() > 0) void'(acc_order.pop_front());
            end
        end
        total++;
        if (inflight > 2 || inflight < 0) begin
            bad++; $display("FAIL inflight got=%0d want=0..2", inflight);
        end
        if (addr_valid && addr_ready) void'(pend.pop_front());
        if (err_addr === 1'b1) obs_err++;
        stalled   = m_valid && !m_ready;
        held_data = m_data;
        held_last = m_last;
        smp_acc = nin; smp_out = nout;
        smp_mvalid = m_valid; smp_addr_ready = addr_ready; smp_s_ready = s_ready;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((pend.size() > 0 || exp_q.size() > 0) && n < budget) begin
            cycle();
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++; $display("FAIL drain_timeout got=pend%0d/beats%0d want=0/0", pend.size(), exp_q.size());
        end
        vld_prob = 100; rdy_prob = 100;
        repeat (3) cycle();
        total++;
        if (obs_err !== exp_err) begin
            bad++; $display("FAIL err_addr_pulses got=%0d want=%0d", obs_err, exp_err);
        end
        total++;
        if (pkt_cnt !== exp_cnt()) begin
            bad++; $display("FAIL pkt_cnt got=%0d want=%0d", pkt_cnt, exp_cnt());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_model();
        @(negedge clock);
        total += 7;
        if (addr_ready !== 1'b1) begin bad++; $display("FAIL rst_addr_ready got=%b want=1", addr_ready); end
        if (s_ready !== '0)      begin bad++; $display("FAIL rst_s_ready got=%b want=0", s_ready); end
        if (m_valid !== 1'b0)    begin bad++; $display("FAIL rst_m_valid got=%b want=0", m_valid); end
        if (m_data !== '0)       begin bad++; $display("FAIL rst_m_data got=%h want=0", m_data); end
        if (m_last !== 1'b0)     begin bad++; $display("FAIL rst_m_last got=%b want=0", m_last); end
        if (err_addr !== 1'b0)   begin bad++; $display("FAIL rst_err_addr got=%b want=0", err_addr); end
        if (pkt_cnt !== '0)      begin bad++; $display("FAIL rst_pkt_cnt got=%0d want=0", pkt_cnt); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_route();
        int run, max_run;
        run = 0; max_run = 0;
        do_reset();
        add_pkt(3, 4, 'hA0);
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (c == 1) begin
                total++;
                if (smp_s_ready !== 6'b000000) begin bad++; $display("FAIL basic_ready_early got=%b want=000000", smp_s_ready); end
            end
            if (c == 2) begin
                total++;
                if (smp_s_ready !== 6'b001000) begin bad++; $display("FAIL basic_ready_on got=%b want=001000", smp_s_ready); end
            end
            run = smp_mvalid ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end
        drain(50);
        total++;
        if (max_run !== 4) begin bad++; $display("FAIL basic_run got=%0d want=4", max_run); end
    endtask

    task automatic test_back_to_back();
        int run, max_run, nv;
        run = 0; max_run = 0; nv = 0;
        do_reset();
        add_pkt(1, 3, -1);
        add_pkt(5, 2, -1);
        for (int c = 0; c < 14; c++) begin
            cycle();
            if (smp_mvalid) nv++;
            run = smp_mvalid ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end
        total++;
        if (max_run !== 5 || nv !== 5) begin bad++; $display("FAIL b2b_run got=%0d/%0d want=5/5", max_run, nv); end
        drain(50);
    endtask

    task automatic test_backpressure();
        int emitted, stall_acc, n;
        emitted = 0; stall_acc = 0; n = 0;
        do_reset();
        add_pkt(2, 8, -1);
        while (emitted < 2 && n < 20) begin
            cycle();
            emitted += smp_out;
            n++;
        end
        rdy_prob = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            stall_acc += smp_acc;
            if (i > 0) begin
                total++;
                if (smp_s_ready !== '0) begin bad++; $display("FAIL bp_ready_low got=%b want=000000", smp_s_ready); end
            end
        end
        total++;
        if (stall_acc !== 1) begin bad++; $display("FAIL bp_skid_beats got=%0d want=1", stall_acc); end
        rdy_prob = 100;
        drain(60);
    endtask

    task automatic test_queue_full();
        int n;
        n = 0;
        do_reset();
        vld_prob = 0;
        add_pkt(0, 2, -1);
        for (int k = 1; k < NUM; k++) add_pkt(k, 1, -1);
        repeat (10) cycle();
        total += 2;
        if (pend.size() !== 1) begin bad++; $display("FAIL qfull_pushes got=%0d want=%0d", NUM - pend.size(), DEPTH + 1); end
        if (smp_addr_ready !== 1'b0) begin bad++; $display("FAIL qfull_ready got=%b want=0", smp_addr_ready); end
        vld_prob = 100;
        while (src_head[0] < 2 && n < 20) begin
            cycle();
            n++;
        end
        cycle();
        total++;
        if (smp_addr_ready !== 1'b1) begin bad++; $display("FAIL qfull_release got=%b want=1", smp_addr_ready); end
        drain(80);
    endtask

    task automatic test_illegal_addr();
        do_reset();
        add_pkt(7, 0, -1);
        add_pkt(2, 3, -1);
        add_pkt(6, 0, -1);
        add_pkt(4, 1, -1);
        drain(60);
    endtask

    task automatic test_random();
        do_reset();
        for (int it = 0; it < 6; it++) begin
            int np;
            vld_prob  = int'($urandom_range(30, 100));
            rdy_prob  = int'($urandom_range(30, 100));
            addr_prob = int'($urandom_range(20, 100));
            np = int'($urandom_range(3, 8));
            for (int p = 0; p < np; p++) add_pkt(int'($urandom_range(0, 7)), int'($urandom_range(1, 5)), -1);
            drain(2000);
        end
    endtask

    task automatic test_reset_mid_packet();
        int emitted, n;
        emitted = 0; n = 0;
        do_reset();
        add_pkt(4, 4, -1);
        add_pkt(1, 2, -1);
        while (emitted < 2 && n < 20) begin
            cycle();
            emitted += smp_out;
            n++;
        end
        @(negedge clock);
        rst_n = 1'b0;
        #1;
        total += 4;
        if (m_valid !== 1'b0)    begin bad++; $display("FAIL mid_rst_m_valid got=%b want=0", m_valid); end
        if (s_ready !== '0)      begin bad++; $display("FAIL mid_rst_s_ready got=%b want=0", s_ready); end
        if (pkt_cnt !== '0)      begin bad++; $display("FAIL mid_rst_pkt_cnt got=%0d want=0", pkt_cnt); end
        if (addr_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_addr_ready got=%b want=1", addr_ready); end
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            addr_valid = 1'b0;
            s_valid = '1;
            s_last = '0;
            m_ready = 1'b1;
            #4;
            total++;
            if (s_ready !== '0 || m_valid !== 1'b0) begin
                bad++; $display("FAIL post_rst_idle got=%b/%b want=000000/0", s_ready, m_valid);
            end
        end
        total++;
        if (addr_ready !== 1'b1) begin bad++; $display("FAIL post_rst_addr_ready got=%b want=1", addr_ready); end
        s_valid = '0;
        add_pkt(0, 2, -1);
        drain(40);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_route();
        test_back_to_back();
        test_backpressure();
        test_queue_full();
        test_illegal_addr();
        test_random();
        test_reset_mid_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
